fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requester feeding a prefetch FIFO.
// Optional misaligned-redirect trap is enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic [31:0] pc_out
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        fetch_misalign
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN} state_t;

  state_t        state, next_state;
  logic [31:0]   pc, next_pc, req_addr, redirect_target;
  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [31:0]   fifo_pc   [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          issue, capture_addr, push, pop, stalled;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign;

  assign redirect_target = redirect_pc;
  assign stalled         = misalign;
  assign fetch_misalign  = misalign;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      misalign <= 1'b0;
    else if (redirect_valid)
      misalign <= (redirect_pc[1:0] != 2'b00);
  end
`else
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
  assign stalled         = 1'b0;
`endif

  // Occupancy alone bounds issue: in S_REQ nothing is outstanding, so a push can never overflow.
  assign issue      = reset && (state == S_REQ) && (count < CW'(FIFO_DEPTH)) && !stalled;
  assign imem_req   = issue || (state != S_REQ);
  assign imem_addr  = (state == S_REQ) ? (issue ? pc : 32'd0) : req_addr;
  assign pc_out     = pc;
  assign pop        = inst_valid && inst_ready;
  assign inst_valid = (count != '0);
  assign inst_data  = inst_valid ? fifo_data[rd_ptr] : 32'd0;
  assign inst_pc    = inst_valid ? fifo_pc[rd_ptr] : 32'd0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= S_REQ;
    else
      state <= next_state;
  end

  // A request seen by memory must be seen through to its ack, so a redirect in the issue
  // cycle parks in S_DRAIN just like one arriving during S_WAIT.
  always_comb begin
    next_state   = state;
    next_pc      = pc;
    capture_addr = 1'b0;
    push         = 1'b0;
    case (state)
      S_REQ: begin
        if (issue) begin
          capture_addr = 1'b1;
          next_state   = redirect_valid ? S_DRAIN : S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          next_state = S_REQ;
          push       = !redirect_valid;
          next_pc    = pc + 32'd4;
        end else if (redirect_valid) begin
          next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (imem_ack)
          next_state = S_REQ;
      end
      default: next_state = S_REQ;
    endcase
    if (redirect_valid)
      next_pc = redirect_target;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= RESET_PC;
      req_addr <= 32'd0;
    end else begin
      pc <= next_pc;
      if (capture_addr)
        req_addr <= pc;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]   <= req_addr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
